// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between the execute path (req0)
// and the branch/address unit (req1), with a tagged response channel.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_illegal_q, rsp_illegal_d;
    logic             gnt0, gnt1;
    logic [OPW-1:0]   sel_op;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        logic ok;
        case (op)
            OPW'(4'b0010), OPW'(4'b1010), OPW'(4'b0110),
            OPW'(4'b0100), OPW'(4'b0101), OPW'(4'b1100),
            OPW'(4'b0111), OPW'(4'b0001), OPW'(4'b1101): ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Arbitration: only in IDLE; on a tie the requester not granted last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign sel_op = gnt1 ? req1_op : req0_op;

    // Next-state and datapath capture for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_illegal_d = rsp_illegal_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d       = EXEC;
                    alu_a_d       = gnt1 ? req1_a : req0_a;
                    alu_b_d       = gnt1 ? req1_b : req0_b;
                    alu_op_d      = sel_op;
                    rsp_id_d      = gnt1;
                    last_d        = gnt1;
                    rsp_illegal_d = !op_legal(sel_op);
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset discards any in-flight op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= OP_ADD;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model and a stand-in ALU.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rv [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [3:0]  rop [2];
    logic        req0_ready, req1_ready;
    logic [31:0] alu_a, alu_b, alu_out, rsp_data;
    logic [3:0]  alu_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_illegal;

    int checks = 0;
    int failures = 0;

    localparam logic [3:0] LOPS [9] = '{4'b0010, 4'b1010, 4'b0110,
        4'b0100, 4'b0101, 4'b1100, 4'b0111, 4'b0001, 4'b1101};

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(rv[0]), .req0_ready(req0_ready),
        .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
        .req1_valid(rv[1]), .req1_ready(req1_ready),
        .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
    );

    // Stand-in ALU; unknown opcodes fall back to add.
    function automatic logic [31:0] alu_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'b1010: return a - b;
            4'b0110: return a & b;
            4'b0100: return a | b;
            4'b0101: return ~(a | b);
            4'b1100: return ~(a & b);
            4'b0111: return (a == 0) ? b : a;
            4'b0001: return (a != 0) ? b : a;
            4'b1101: return (a == b) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        foreach (LOPS[i]) if (LOPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    always_comb alu_out = alu_f(alu_a, alu_b, alu_op);

    task automatic reset_dut();
        reset_n = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Present one op on requester id and drop valid after it is accepted.
    task automatic issue(input int id, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op,
                         output bit got);
        got = 1'b0;
        @(posedge clk); #1;
        rv[id] = 1'b1; ra[id] = a; rb[id] = b; rop[id] = op;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = (id == 0) ? req0_ready : req1_ready;
        end
        @(posedge clk); #1;
        rv[id] = 1'b0;
    endtask

    task automatic test_reset();
        rv[0] = 1'b0; rv[1] = 1'b0; rsp_ready = 1'b0;
        ra[0] = '0; rb[0] = '0; rop[0] = '0;
        ra[1] = '0; rb[1] = '0; rop[1] = '0;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 32'd0 ||
            rsp_illegal !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
            alu_op !== 4'b0010 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset v=%b id=%b d=%h ill=%b a=%h b=%h op=%b r=%b%b",
                     rsp_valid, rsp_id, rsp_data, rsp_illegal, alu_a, alu_b,
                     alu_op, req0_ready, req1_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        rv[0] = 1'b1; ra[0] = 5; rb[0] = 7; rop[0] = 4'b0010; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        rv[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7 ||
            alu_op !== 4'b0010) begin
            failures++;
            $display("FAIL basic_exec v=%b a=%0d b=%0d op=%b want 0 5 7 0010",
                     rsp_valid, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd12 ||
            rsp_illegal !== 1'b0) begin
            failures++;
            $display("FAIL basic_rsp v=%b id=%b d=%0d ill=%b want 1 0 12 0",
                     rsp_valid, rsp_id, rsp_data, rsp_illegal);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_drain v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_alternate();
        logic [31:0] exp_d;
        reset_dut();
        @(posedge clk); #1;
        rv[0] = 1'b1; ra[0] = 9; rb[0] = 4; rop[0] = 4'b1010;
        rv[1] = 1'b1; ra[1] = 32'hF0; rb[1] = 32'h3C; rop[1] = 4'b0110;
        for (int g = 0; g < 4; g++) begin
            int t = 0;
            logic e1;
            e1 = (g % 2 == 1);
            @(negedge clk);
            while (!(req0_ready || req1_ready) && t < 10) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (req0_ready !== !e1 || req1_ready !== e1) begin
                failures++;
                $display("FAIL alt_grant g=%0d r0=%b r1=%b want %b %b",
                         g, req0_ready, req1_ready, !e1, e1);
            end
            @(negedge clk);
            @(negedge clk);
            exp_d = e1 ? 32'h30 : 32'd5;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== e1 || rsp_data !== exp_d) begin
                failures++;
                $display("FAIL alt_rsp g=%0d v=%b id=%b d=%h want 1 %b %h",
                         g, rsp_valid, rsp_id, rsp_data, e1, exp_d);
            end
        end
        @(posedge clk); #1;
        rv[0] = 1'b0; rv[1] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit got;
        int bad = 0;
        rsp_ready = 1'b0;
        issue(0, 32'h11, 32'h22, 4'b0010, got);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!got || rsp_valid !== 1'b1 || rsp_data !== 32'h33) begin
            failures++;
            $display("FAIL bp_first got=%b v=%b d=%h want 1 1 33",
                     got, rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
        rv[1] = 1'b1; ra[1] = 32'hFF; rb[1] = 32'h0F; rop[1] = 4'b0110;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h33 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold i=%0d v=%b d=%h r=%b%b want 1 33 00",
                         i, rsp_valid, rsp_data, req0_ready, req1_ready);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release r1=%b v=%b want 1 0", req1_ready, rsp_valid);
        end
        @(posedge clk); #1;
        rv[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h0F) begin
            failures++;
            $display("FAIL bp_next v=%b id=%b d=%h want 1 1 0f",
                     rsp_valid, rsp_id, rsp_data);
        end
        bad = bad;
    endtask

    task automatic test_branch_ops();
        logic [31:0] ta [3] = '{32'd0, 32'd3, 32'd8};
        logic [31:0] tb [3] = '{32'd16, 32'd16, 32'd8};
        logic [3:0]  to [3] = '{4'b0111, 4'b0111, 4'b1101};
        logic [31:0] te [3] = '{32'd16, 32'd3, 32'd1};
        bit got;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1, ta[i], tb[i], to[i], got);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (!got || rsp_valid !== 1'b1 || rsp_id !== 1'b1 ||
                rsp_data !== te[i] || rsp_illegal !== 1'b0) begin
                failures++;
                $display("FAIL branch_op i=%0d got=%b v=%b id=%b d=%0d ill=%b want d=%0d",
                         i, got, rsp_valid, rsp_id, rsp_data, rsp_illegal, te[i]);
            end
        end
    endtask

    task automatic test_illegal();
        bit got;
        rsp_ready = 1'b1;
        issue(0, 32'd2, 32'd3, 4'b1111, got);
        @(negedge clk);
        checks++;
        if (alu_op !== 4'b1111) begin
            failures++;
            $display("FAIL illegal_issue op=%b want 1111", alu_op);
        end
        @(negedge clk);
        checks++;
        if (!got || rsp_valid !== 1'b1 || rsp_data !== 32'd5 ||
            rsp_illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_rsp got=%b v=%b d=%0d ill=%b want 1 5 1",
                     got, rsp_valid, rsp_data, rsp_illegal);
        end
        issue(0, 32'd1, 32'd1, 4'b0010, got);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!got || rsp_data !== 32'd2 || rsp_illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear got=%b d=%0d ill=%b want 2 0",
                     got, rsp_data, rsp_illegal);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        rsp_ready = 1'b1;
        issue(1, 32'd1, 32'd2, 4'b1010, got);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (!got || rsp_valid !== 1'b0 || alu_op !== 4'b0010 || alu_a !== 32'd0) begin
            failures++;
            $display("FAIL rst_exec got=%b v=%b op=%b a=%h want 0 0010 0",
                     got, rsp_valid, alu_op, alu_a);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rsp_ready = 1'b0;
        issue(1, 32'd7, 32'd7, 4'b0100, got);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (!got || rsp_valid !== 1'b0 || rsp_data !== 32'd0 ||
            alu_op !== 4'b0010 || rsp_id !== 1'b0) begin
            failures++;
            $display("FAIL rst_resp got=%b v=%b d=%h op=%b id=%b want 0 0 0010 0",
                     got, rsp_valid, rsp_data, alu_op, rsp_id);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b1; ra[0] = 4; rb[0] = 4; rop[0] = 4'b0010;
        rv[1] = 1'b1; ra[1] = 6; rb[1] = 6; rop[1] = 4'b0010;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_first_grant r0=%b r1=%b want 1 0",
                     req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        rv[0] = 1'b0; rv[1] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic new_op(input int i);
        ra[i] = $urandom;
        rb[i] = ($urandom % 4 == 0) ? ra[i] : $urandom;
        rop[i] = ($urandom % 4 == 0) ? 4'($urandom) : LOPS[$urandom % 9];
    endtask

    // Random traffic; the model tracks outstanding work as a timeline:
    // accept, one execute cycle, then a response held until consumed.
    task automatic test_random();
        bit busy = 0;
        int age = 0;
        int last = 1;
        bit g [2];
        logic e0, e1, eid, eill;
        logic [31:0] ea, eb, ed;
        logic [3:0] eop;
        int served = 0;
        reset_dut();
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = $urandom % 2;
            new_op(i);
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            g[0] = 0; g[1] = 0;
            if (!busy) begin
                e0 = rv[0] && (!rv[1] || last == 1);
                e1 = rv[1] && (!rv[0] || last == 0);
                checks++;
                if (req0_ready !== e0 || req1_ready !== e1 || rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_grant c=%0d r=%b%b v=%b want r=%b%b v=0",
                             c, req0_ready, req1_ready, rsp_valid, e0, e1);
                end
                if (e0 || e1) begin
                    int id;
                    id = e1 ? 1 : 0;
                    g[id] = 1;
                    busy = 1; age = 0; last = id;
                    eid = e1; ea = ra[id]; eb = rb[id]; eop = rop[id];
                    ed = alu_f(ea, eb, eop);
                    eill = !is_legal(eop);
                end
            end else begin
                age++;
                checks++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_busy_ready c=%0d r=%b%b want 00",
                             c, req0_ready, req1_ready);
                end
                if (age == 1) begin
                    checks++;
                    if (rsp_valid !== 1'b0 || alu_a !== ea || alu_b !== eb ||
                        alu_op !== eop) begin
                        failures++;
                        $display("FAIL rand_exec c=%0d v=%b a=%h b=%h op=%b want 0 %h %h %b",
                                 c, rsp_valid, alu_a, alu_b, alu_op, ea, eb, eop);
                    end
                end else begin
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== ed ||
                        rsp_illegal !== eill) begin
                        failures++;
                        $display("FAIL rand_rsp c=%0d v=%b id=%b d=%h ill=%b want 1 %b %h %b",
                                 c, rsp_valid, rsp_id, rsp_data, rsp_illegal, eid, ed, eill);
                    end
                    if (rsp_ready) begin
                        busy = 0;
                        served++;
                    end
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    rv[i] = ($urandom % 3 != 0);
                    new_op(i);
                end else if (rv[i]) begin
                    if ($urandom % 10 == 0) rv[i] = 1'b0;
                end else if ($urandom % 2 == 1) begin
                    rv[i] = 1'b1;
                    new_op(i);
                end
            end
            rsp_ready = ($urandom % 4 != 0);
        end
        checks++;
        if (served < 50) begin
            failures++;
            $display("FAIL rand_progress served=%0d want >=50", served);
        end
        rv[0] = 1'b0; rv[1] = 1'b0; rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_backpressure();
        test_branch_ops();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
